cache_ctrl_wb: RTL and testbench
================================

# cache_ctrl_wb

Direct-mapped, write-back, write-allocate cache controller sitting between the CPU load/store port and the 1 KiB, 128-bit-block main memory. It holds 4 lines of 4 words (tag, valid, dirty, data), serves hits from its own arrays, and on a miss writes back the dirty victim before fetching the new block. It owns all timing of the memory port and models a fixed memory access latency.

## Interface
Parameters:
- `MEM_LAT`, default 4: cycles the memory port is held for each block transfer; legal range 1..15.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_read`  in  1  load request.
- `cpu_write`  in  1  store request.
- `cpu_addr`  in  10  byte address: tag [9:6], index [5:4], word [3:2], byte [1:0] (ignored).
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data, valid while `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `mem_addr`  out  10  block address; [3:0] always 0.
- `mem_wdata`  out  128  victim block; word 0 in [127:96], word 3 in [31:0].
- `mem_write`  out  1  memory write enable.
- `mem_rdata`  in  128  block read data, same word order as `mem_wdata`.
- `hit_cnt`  out  16  completed-hit counter; wraps at 0xFFFF.
- `miss_cnt`  out  16  miss counter; wraps at 0xFFFF.

## Operation
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: if `cpu_write` or `cpu_read` is high, latch address, wdata, and op, then go to COMPARE. If both are high, the op is a write.
- COMPARE: hit = valid[idx] and tag[idx] matches the latched tag.
  - Hit on read: drive `cpu_rdata` with the word, pulse `cpu_ready`, `hit_cnt`+1, go to IDLE.
  - Hit on write: update the word, set dirty, pulse `cpu_ready` (`cpu_rdata` = 0), `hit_cnt`+1, go to IDLE.
  - Miss: `miss_cnt`+1 (once per request). Go to WRITEBACK if valid and dirty, else go to ALLOCATE.
- WRITEBACK:
  - `mem_addr` = {victim tag, idx, 4'b0}, `mem_wdata` = victim block, `mem_write` = 1.
  - Held for exactly `MEM_LAT` cycles, then clear dirty and go to ALLOCATE.
- ALLOCATE:
  - `mem_addr` = {new tag, idx, 4'b0}, `mem_write` = 0, held for `MEM_LAT` cycles.
  - On the last cycle, capture `mem_rdata` into the line and set valid=1, dirty=0, tag=new.
  - Return to COMPARE; the re-compare always hits, so the hit counter also increments.
- `mem_addr`, `mem_wdata` and `mem_write` are registered and must not glitch. The memory writes combinationally, so address and data must be stable whenever `mem_write`=1. Outside WRITEBACK/ALLOCATE, `mem_write`=0 and `mem_addr` holds its last value.
- Requests arriving outside IDLE are ignored. The CPU holds its request until `cpu_ready`. A request still high in the cycle after `cpu_ready` starts a new access.
- A down-counter of 4 bits, loaded with `MEM_LAT`-1 on state entry, times WRITEBACK and ALLOCATE.

## Timing
- Reset (synchronous) sets: state = IDLE, all valid/dirty = 0, `cpu_ready` = 0, `cpu_rdata` = 0, `mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0, both counters = 0. Data and tag arrays are not reset.
- Reset mid-WRITEBACK drops `mem_write` at the same edge. A partially timed write-back is not retried, and the line becomes invalid.
- The request is sampled at edge k in IDLE.
- Hit: `cpu_ready` is high during cycle k+1 (1-cycle latency after sample).
- Clean miss: `cpu_ready` is high during cycle k+2+`MEM_LAT`.
- Dirty miss: `cpu_ready` is high during cycle k+2+2·`MEM_LAT`.
- `mem_write` is high for exactly `MEM_LAT` consecutive cycles per write-back. It is never high in ALLOCATE.
- `cpu_ready` is never high for two consecutive cycles.

## Test plan
- After reset, read 0x008 with `MEM_LAT`=4: `mem_addr`=0x000 for 4 cycles, `mem_write`=0. `cpu_ready` at k+6 with `cpu_rdata`=0x91B3DF89. `miss_cnt`=1, `hit_cnt`=1.
- Read 0x000: returns 0xC83FA926 at k+1, no memory activity, `hit_cnt`=2.
- Write 0xDEADBEEF to 0x004: hit, `cpu_ready` at k+1, no `mem_write`, line 0 becomes dirty.
- Read 0x040: dirty miss.
  - `mem_write`=1 for 4 cycles with `mem_addr`=0x000 and `mem_wdata`={C83FA926, DEADBEEF, 91B3DF89, 1DB9E076}.
  - Then allocate 0x040; `cpu_rdata`=0x25F000D6 at k+10.
- Read 0x004 afterwards: clean miss, returns 0xDEADBEEF.
- Assert `reset` in the 2nd WRITEBACK cycle: `mem_write`=0 from the next cycle, state is IDLE, and a following read of 0x000 misses.
- Assert `cpu_read` and `cpu_write` together: treated as a write, and the dirty bit is set.

Source files
------------

// File: rtl/cache_ctrl_wb.sv
// Direct-mapped, write-back, write-allocate cache controller.
// 4 lines x 4 words, tag[9:6] index[5:4] word[3:2]. The memory port is
// block wide and held for MEM_LAT cycles per transfer.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a load/store; ignores the cycle cpu_ready is up
// COMPARE   | tag compare; hit completes, miss selects WRITEBACK/ALLOCATE
// WRITEBACK | dirty victim driven on the memory port for MEM_LAT cycles
// ALLOCATE  | new block fetched; captured on the last timed cycle
module cache_ctrl_wb #(
  parameter int MEM_LAT = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_read,
  input  logic         cpu_write,
  input  logic [9:0]   cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_ready,
  output logic [9:0]   mem_addr,
  output logic [127:0] mem_wdata,
  output logic         mem_write,
  input  logic [127:0] mem_rdata,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t      state;
  logic [3:0]  timer;
  logic [3:0]  req_tag;
  logic [1:0]  req_idx;
  logic [1:0]  req_word;
  logic [31:0] req_wdata;
  logic        req_write;

  logic [3:0]  valid;
  logic [3:0]  dirty;
  logic [3:0]  tag_arr  [4];
  logic [31:0] data_arr [4][4];

  logic        hit;
  logic [127:0] victim;

  // byte offset is not used by a word-granular cache
  logic unused_byte;
  assign unused_byte = ^cpu_addr[1:0];

  // tag compare and victim block assembly for the latched index
  assign hit    = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign victim = {data_arr[req_idx][0], data_arr[req_idx][1],
                   data_arr[req_idx][2], data_arr[req_idx][3]};

  // controller FSM with registered CPU and memory port outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      valid     <= '0;
      dirty     <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      req_tag   <= '0;
      req_idx   <= '0;
      req_word  <= '0;
      req_wdata <= '0;
      req_write <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      unique case (state)
        IDLE: begin
          // the request is still held during the completion cycle
          if (!cpu_ready && (cpu_read || cpu_write)) begin
            req_tag   <= cpu_addr[9:6];
            req_idx   <= cpu_addr[5:4];
            req_word  <= cpu_addr[3:2];
            req_wdata <= cpu_wdata;
            req_write <= cpu_write;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            cpu_ready <= 1'b1;
            hit_cnt   <= hit_cnt + 16'd1;
            if (req_write) begin
              data_arr[req_idx][req_word] <= req_wdata;
              dirty[req_idx]              <= 1'b1;
            end else begin
              cpu_rdata <= data_arr[req_idx][req_word];
            end
            state <= IDLE;
          end else begin
            miss_cnt <= miss_cnt + 16'd1;
            timer    <= LAT_M1;
            if (valid[req_idx] && dirty[req_idx]) begin
              mem_addr  <= {tag_arr[req_idx], req_idx, 4'b0000};
              mem_wdata <= victim;
              mem_write <= 1'b1;
              state     <= WRITEBACK;
            end else begin
              mem_addr  <= {req_tag, req_idx, 4'b0000};
              mem_write <= 1'b0;
              state     <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (timer == 4'd0) begin
            dirty[req_idx] <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= {req_tag, req_idx, 4'b0000};
            timer          <= LAT_M1;
            state          <= ALLOCATE;
          end else begin
            timer <= timer - 4'd1;
          end
        end
        ALLOCATE: begin
          if (timer == 4'd0) begin
            data_arr[req_idx][0] <= mem_rdata[127:96];
            data_arr[req_idx][1] <= mem_rdata[95:64];
            data_arr[req_idx][2] <= mem_rdata[63:32];
            data_arr[req_idx][3] <= mem_rdata[31:0];
            tag_arr[req_idx]     <= req_tag;
            valid[req_idx]       <= 1'b1;
            dirty[req_idx]       <= 1'b0;
            state                <= COMPARE;
          end else begin
            timer <= timer - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Bench for cache_ctrl_wb: block memory model, reference cache model and a
// scoreboard of expected load data and completion latency.
module tb_cache_ctrl_wb;

  localparam int L = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_read, cpu_write;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_ready;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_write;
  logic [15:0]  hit_cnt, miss_cnt;

  cache_ctrl_wb #(.MEM_LAT(L)) dut (
    .clock(clock), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [7:0] wa);
    case (wa)
      8'h00:   return 32'hC83FA926;
      8'h01:   return 32'h12345678;
      8'h02:   return 32'h91B3DF89;
      8'h03:   return 32'h1DB9E076;
      8'h10:   return 32'h25F000D6;
      default: return 32'h5A170000 ^ ({24'b0, wa} * 32'h9E3779B1);
    endcase
  endfunction

  // main memory, word indexed
  logic [31:0] mem  [256];
  logic [31:0] refm [256];
  assign mem_rdata = {mem[{mem_addr[9:4], 2'd0}], mem[{mem_addr[9:4], 2'd1}],
                      mem[{mem_addr[9:4], 2'd2}], mem[{mem_addr[9:4], 2'd3}]};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(8'(i));
    forever begin
      @(negedge clock);
      if (mem_write) begin
        mem[{mem_addr[9:4], 2'd0}] = mem_wdata[127:96];
        mem[{mem_addr[9:4], 2'd1}] = mem_wdata[95:64];
        mem[{mem_addr[9:4], 2'd2}] = mem_wdata[63:32];
        mem[{mem_addr[9:4], 2'd3}] = mem_wdata[31:0];
      end
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          k;
  } exp_t;
  exp_t sbq[$];

  int           run = 0;
  bit           stable = 1'b1;
  logic [9:0]   wb_addr = '0;
  logic [127:0] wb_data = '0;
  int           wr_total = 0;
  logic [31:0]  last_rdata = '0;

  // completion scoreboard and write-back run monitor
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (cpu_ready) begin
      chk("sb_nonempty", 128'(sbq.size() != 0), 128'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("rdata", cpu_rdata, e.rdata);
        chk("latency", 128'(cyc - e.k), 128'(e.lat));
      end
      last_rdata = cpu_rdata;
    end
    if (reset) begin
      run = 0;
      stable = 1'b1;
    end else if (mem_write) begin
      if (run > 0 && (mem_addr !== wb_addr || mem_wdata !== wb_data)) stable = 1'b0;
      run++;
      wb_addr = mem_addr;
      wb_data = mem_wdata;
      wr_total++;
    end else if (run > 0) begin
      chk("wb_len", 128'(run), 128'(L));
      chk("wb_stable", 128'(stable), 128'd1);
      run = 0;
      stable = 1'b1;
    end
  end

  // reference cache state
  logic [3:0] mv, md;
  logic [3:0] mt [4];
  int         e_hit, e_miss;
  logic [9:0] e_maddr;

  task automatic model_reset();
    mv = '0;
    md = '0;
    e_hit = 0;
    e_miss = 0;
    e_maddr = '0;
    for (int i = 0; i < 256; i++) refm[i] = mem[i];
  endtask

  task automatic do_req(input logic wr, input logic rd, input logic [9:0] a, input logic [31:0] wd);
    logic [1:0] idx;
    logic [3:0] tg;
    logic [9:0] vaddr;
    int         lat, exp_wr, wr0, t;
    bit         dirty_miss;
    exp_t       e;
    idx = a[5:4];
    tg  = a[9:6];
    exp_wr = 0;
    dirty_miss = 1'b0;
    vaddr = {mt[idx], idx, 4'b0000};
    e_hit++;
    if (mv[idx] && mt[idx] == tg) begin
      lat = 1;
    end else begin
      e_miss++;
      if (mv[idx] && md[idx]) begin
        lat = 2 + 2 * L;
        exp_wr = L;
        dirty_miss = 1'b1;
      end else begin
        lat = 2 + L;
      end
      mv[idx] = 1'b1;
      md[idx] = 1'b0;
      mt[idx] = tg;
      e_maddr = {tg, idx, 4'b0000};
    end
    if (wr) begin
      refm[a[9:2]] = wd;
      md[idx] = 1'b1;
      e.rdata = '0;
    end else begin
      e.rdata = refm[a[9:2]];
    end
    @(posedge clock); #1;
    cpu_read = rd;
    cpu_write = wr;
    cpu_addr = a;
    cpu_wdata = wd;
    e.lat = lat;
    e.k = cyc + 1;
    sbq.push_back(e);
    wr0 = wr_total;
    t = 0;
    do begin
      @(posedge clock); #1;
      t++;
    end while (!cpu_ready && t < 100);
    chk("ready_seen", 128'(cpu_ready), 128'd1);
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    if (!cpu_ready) sbq.delete();
    @(negedge clock);
    chk("hit_cnt", hit_cnt, 128'(e_hit));
    chk("miss_cnt", miss_cnt, 128'(e_miss));
    chk("mem_addr", mem_addr, e_maddr);
    chk("wb_cycles", 128'(wr_total - wr0), 128'(exp_wr));
    if (dirty_miss) chk("wb_addr", wb_addr, vaddr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    logic [9:0] ra;
    int op;
    reset = 1'b1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    #1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);

    do_req(1'b0, 1'b1, 10'h008, 32'h0);
    chk("tp_rd008", last_rdata, 32'h91B3DF89);
    do_req(1'b0, 1'b1, 10'h000, 32'h0);
    chk("tp_rd000", last_rdata, 32'hC83FA926);
    do_req(1'b1, 1'b0, 10'h004, 32'hDEADBEEF);
    do_req(1'b0, 1'b1, 10'h040, 32'h0);
    chk("tp_wb_data", wb_data, 128'hC83FA926_DEADBEEF_91B3DF89_1DB9E076);
    chk("tp_rd040", last_rdata, 32'h25F000D6);
    do_req(1'b0, 1'b1, 10'h004, 32'h0);
    chk("tp_rd004", last_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 40; i++) begin
      ra = {2'b00, 2'($urandom), 2'($urandom), 2'($urandom), 2'b00};
      op = $urandom_range(0, 2);
      do_req(op != 0, op != 1, ra, $urandom);
    end

    do_req(1'b1, 1'b1, 10'h090, 32'hA5A55A5A);
    do_req(1'b0, 1'b1, 10'h1D0, 32'h0);
    do_req(1'b0, 1'b1, 10'h090, 32'h0);
    chk("both_is_write", last_rdata, 32'hA5A55A5A);

    // reset in the second write-back cycle
    do_req(1'b1, 1'b0, 10'h000, 32'hCAFEF00D);
    @(posedge clock); #1;
    cpu_read = 1'b1;
    cpu_addr = 10'h3C0;
    k = cyc + 1;
    repeat (3) @(posedge clock);
    #1;
    chk("wb_active", mem_write, 1);
    chk("wb_cycle_index", 128'(cyc - k), 128'd2);
    reset = 1'b1;
    cpu_read = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_mem_write", mem_write, 0);
    chk("abort_ready", cpu_ready, 0);
    chk("abort_hit_cnt", hit_cnt, 0);
    chk("abort_miss_cnt", miss_cnt, 0);
    model_reset();
    do_req(1'b0, 1'b1, 10'h000, 32'h0);

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
